// File: rtl/tiny_dnn_host_port.sv
// tiny_dnn_host_port
// Host-side stream adapter for the tiny_dnn accelerator. A host command loads
// one weight block, one bias block, or one sample. For a sample it then
// collects that sample's results.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_op[1:0]                    0=weight 1=bias 2=run 3=reserved (sets err)
//   cmd_len[11:0], cmd_rlen[11:0]  source / result word count minus one
//   in_valid/in_ready/in_data      host push into the TX FIFO
//   wwrite, bwrite, run            accelerator mode strobes (registered decode)
//   src_valid/src_ready/src_data/src_last   source stream to the accelerator
//   dst_valid/dst_ready/dst_data   result stream from the accelerator
//   out_valid/out_ready/out_data/out_last   result stream to the host
//   busy                           command in progress
//   err                            sticky protocol error flag
module tiny_dnn_host_port #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [11:0] cmd_len,
  input  logic [11:0] cmd_rlen,
  input  logic        in_valid,
  output logic        in_ready,
  input  real         in_data,
  output logic        wwrite,
  output logic        bwrite,
  output logic        run,
  output logic        src_valid,
  input  logic        src_ready,
  output real         src_data,
  output logic        src_last,
  input  logic        dst_valid,
  output logic        dst_ready,
  input  real         dst_data,
  output logic        out_valid,
  input  logic        out_ready,
  output real         out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] OP_W   = 2'd0;
  localparam logic [1:0] OP_B   = 2'd1;
  localparam logic [1:0] OP_R   = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, SEND, RECV} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [11:0] len_q, len_d;
  logic [11:0] rlen_q, rlen_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [11:0] rx_cnt_q, rx_cnt_d;
  logic        err_q, err_d;

  // TX FIFO
  real         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // 2-entry output buffer
  real         ob_data_q [2];
  logic [1:0]  ob_last_q;
  logic        ob_wr_q, ob_wr_d;
  logic        ob_rd_q, ob_rd_d;
  logic [1:0]  ob_cnt_q, ob_cnt_d;

  logic fifo_empty, fifo_full, ob_empty, ob_full;
  logic src_valid_int, dst_ready_int;
  logic push, pop, dst_xfer, out_pop, rx_last;

  assign fifo_empty    = (cnt_q == '0);
  assign fifo_full     = (cnt_q == FIFO_FULL);
  assign ob_empty      = (ob_cnt_q == 2'd0);
  assign ob_full       = (ob_cnt_q == 2'd2);
  assign src_valid_int = (state_q == SEND) && !fifo_empty;
  // dst_ready uses the registered fill level, so a same-cycle pop of a full
  // buffer only frees a slot from the following cycle.
  assign dst_ready_int = (state_q == RECV) && !ob_full;
  assign push          = in_valid && !fifo_full;
  assign pop           = src_valid_int && src_ready;
  assign dst_xfer      = dst_valid && dst_ready_int;
  assign out_pop       = !ob_empty && out_ready;
  assign rx_last       = (rx_cnt_q == rlen_q);

  // State and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      len_q    <= '0;
      rlen_q   <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ob_wr_q  <= 1'b0;
      ob_rd_q  <= 1'b0;
      ob_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      rlen_q   <= rlen_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ob_wr_q  <= ob_wr_d;
      ob_rd_q  <= ob_rd_d;
      ob_cnt_q <= ob_cnt_d;
    end
  end

  // Data storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
    if (dst_xfer) begin
      ob_data_q[ob_wr_q] <= dst_data;
      ob_last_q[ob_wr_q] <= rx_last;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_d    = len_q;
    rlen_d   = rlen_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_RSV) begin
            err_d = 1'b1;
          end else begin
            op_d     = cmd_op;
            len_d    = cmd_len;
            rlen_d   = cmd_rlen;
            tx_cnt_d = '0;
            rx_cnt_d = '0;
            state_d  = SETUP;
          end
        end
      end
      SETUP: state_d = SEND;
      SEND: begin
        if (pop) begin
          tx_cnt_d = tx_cnt_q + 12'd1;
          // Compare before increment: len=4095 wraps the counter harmlessly.
          if (tx_cnt_q == len_q) state_d = (op_q == OP_R) ? RECV : IDLE;
        end
      end
      RECV: begin
        if (dst_xfer) begin
          rx_cnt_d = rx_cnt_q + 12'd1;
          if (rx_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (dst_valid && (state_q != RECV)) err_d = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    ob_wr_d = dst_xfer ? ~ob_wr_q : ob_wr_q;
    ob_rd_d = out_pop  ? ~ob_rd_q : ob_rd_q;
    case ({dst_xfer, out_pop})
      2'b10:   ob_cnt_d = ob_cnt_q + 2'd1;
      2'b01:   ob_cnt_d = ob_cnt_q - 2'd1;
      default: ob_cnt_d = ob_cnt_q;
    endcase
  end

  // Outputs: strobes come from registered state and latched op only.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    in_ready  = !fifo_full;
    wwrite    = ((state_q == SETUP) || (state_q == SEND)) && (op_q == OP_W);
    bwrite    = ((state_q == SETUP) || (state_q == SEND)) && (op_q == OP_B);
    run       = (state_q != IDLE) && (op_q == OP_R);
    src_valid = src_valid_int;
    src_data  = fifo_empty ? 0.0 : mem_q[rd_ptr_q];
    src_last  = src_valid_int && (tx_cnt_q == len_q);
    dst_ready = dst_ready_int;
    out_valid = !ob_empty;
    out_data  = ob_empty ? 0.0 : ob_data_q[ob_rd_q];
    out_last  = !ob_empty && ob_last_q[ob_rd_q];
    err       = err_q;
  end

endmodule

// File: tb/tb_tiny_dnn_host_port.sv
// Directed bench for tiny_dnn_host_port with a scoreboard: source words are
// queued when pushed into the TX FIFO, result words are queued when the
// modelled accelerator hands them over, and both are checked on the way out.
module tb_tiny_dnn_host_port;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_len, cmd_rlen;
  logic        in_valid, in_ready;
  real         in_data;
  logic        wwrite, bwrite, run;
  logic        src_valid, src_ready, src_last;
  real         src_data;
  logic        dst_valid, dst_ready;
  real         dst_data;
  logic        out_valid, out_ready, out_last;
  real         out_data;
  logic        busy, err;

  tiny_dnn_host_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_rlen(cmd_rlen),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wwrite(wwrite), .bwrite(bwrite), .run(run),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_last(src_last),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    real d;
    bit  last;
  } exp_t;

  real  feed_q[$];
  real  src_q[$];
  exp_t out_q[$];

  int   errors = 0;
  int   checks = 0;
  int   occ = 0;
  int   src_left = 0, dst_left = 0;
  int   src_xfers = 0, dst_xfers = 0, out_xfers = 0;
  bit   recv_phase = 0, last_dst_seen = 0, acc_en = 0, saw_full = 0;
  int   src_mode = 0, out_mode = 0, dst_mode = 0;
  logic [1:0] cur_op = 2'd0;
  real  word_next = 1.0;
  real  dst_next  = 100.0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input real obs, input real exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  task automatic feed(input int n);
    repeat (n) begin
      feed_q.push_back(word_next);
      word_next += 1.0;
    end
  endtask

  // One clock: observe handshakes at negedge, then drive inputs at posedge+1.
  task automatic tick();
    exp_t e;
    real  r;
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready_vs_occ", in_ready, occ != DEPTH);
      if (!in_ready) saw_full = 1;
      chk("src_last_level", src_last, src_valid && (src_left == 1));
      if (src_valid && src_ready) begin
        src_xfers++;
        occ--;
        if (src_q.size() == 0) chk("src_spurious", src_valid, 1'b0);
        else begin
          r = src_q.pop_front();
          chk_r("src_data", src_data, r);
          if (src_left == 1 && cur_op == 2'd2) recv_phase = 1;
          src_left--;
        end
      end
      if (in_valid && in_ready) begin
        src_q.push_back(in_data);
        void'(feed_q.pop_front());
        occ++;
      end
      if (dst_valid && dst_ready) begin
        dst_xfers++;
        e.d = dst_next;
        e.last = (dst_left == 1);
        out_q.push_back(e);
        dst_next += 1.5;
        dst_left--;
        if (dst_left == 0) begin
          last_dst_seen = 1;
          recv_phase = 0;
        end
      end
      if (out_valid && out_ready) begin
        out_xfers++;
        if (out_q.size() == 0) chk("out_spurious", out_valid, 1'b0);
        else begin
          e = out_q.pop_front();
          chk_r("out_data", out_data, e.d);
          chk("out_last", out_last, e.last);
        end
      end
    end
    @(posedge clk);
    #1;
    if (last_dst_seen) begin
      chk("run_after_last", run, 1'b0);
      chk("dst_ready_after_last", dst_ready, 1'b0);
      chk("cmd_ready_after_last", cmd_ready, 1'b1);
      last_dst_seen = 0;
    end
    case (src_mode)
      0:       src_ready = 1'b1;
      1:       src_ready = 1'($urandom_range(0, 1));
      2:       src_ready = 1'b0;
      default: src_ready = ~src_ready;
    endcase
    out_ready = (out_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (acc_en) begin
      dst_valid = recv_phase && (dst_left > 0) &&
                  ((dst_mode == 0) || ($urandom_range(0, 1) != 0));
      dst_data  = dst_next;
    end
    in_valid = (feed_q.size() > 0);
    in_data  = in_valid ? feed_q[0] : 0.0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input int len, input int rlen);
    int n;
    cur_op     = op;
    src_left   = (op == 2'd3) ? 0 : len + 1;
    dst_left   = (op == 2'd2) ? rlen + 1 : 0;
    recv_phase = 0;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_len    = 12'(len);
    cmd_rlen   = 12'(rlen);
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic clear_model();
    occ = 0;
    src_q.delete();
    out_q.delete();
    feed_q.delete();
    src_left = 0;
    dst_left = 0;
    recv_phase = 0;
    last_dst_seen = 0;
  endtask

  initial begin
    int n, nw;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = '0; cmd_rlen = '0;
    in_valid = 1'b0; in_data = 0.0;
    src_ready = 1'b0; dst_valid = 1'b0; dst_data = 0.0; out_ready = 1'b1;

    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wwrite", wwrite, 1'b0);
    chk("rst_bwrite", bwrite, 1'b0);
    chk("rst_run", run, 1'b0);
    chk("rst_src_valid", src_valid, 1'b0);
    chk("rst_src_last", src_last, 1'b0);
    chk("rst_dst_ready", dst_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_err", err, 1'b0);
    chk_r("rst_src_data", src_data, 0.0);
    chk_r("rst_out_data", out_data, 0.0);
    rst_n = 1'b1;
    clear_model();
    tick();

    // Weight load, len=3, words pre-pushed
    src_mode = 0;
    feed(4);
    n = 0;
    while (feed_q.size() > 0 && n < 20) begin tick(); n++; end
    src_xfers = 0;
    send_cmd(2'd0, 3, 0);
    chk("w_setup_wwrite", wwrite, 1'b1);
    chk("w_setup_src_valid", src_valid, 1'b0);
    n = 0; nw = 0;
    while (busy && n < 20) begin
      if (wwrite) nw++;
      tick();
      n++;
    end
    chk_i("w_wwrite_cycles", nw, 5);
    chk_i("w_src_xfers", src_xfers, 4);
    chk("w_wwrite_drop", wwrite, 1'b0);

    // Bias, len=0, word arrives late
    src_xfers = 0;
    send_cmd(2'd1, 0, 0);
    repeat (3) begin
      chk("b_wait_bwrite", bwrite, 1'b1);
      chk("b_wait_src_valid", src_valid, 1'b0);
      tick();
    end
    feed(1);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk_i("b_src_xfers", src_xfers, 1);
    chk("b_idle", busy, 1'b0);
    chk("b_bwrite_drop", bwrite, 1'b0);

    // Run with random stalls: 784 source words, 10 results
    src_mode = 1; out_mode = 1; dst_mode = 1; acc_en = 1;
    src_xfers = 0; dst_xfers = 0; out_xfers = 0;
    feed(784);
    send_cmd(2'd2, 783, 9);
    n = 0;
    while ((busy || out_valid || out_q.size() > 0) && n < 6000) begin tick(); n++; end
    chk_i("r_src_xfers", src_xfers, 784);
    chk_i("r_dst_xfers", dst_xfers, 10);
    chk_i("r_out_xfers", out_xfers, 10);
    chk_i("r_src_q_left", src_q.size(), 0);
    chk("r_busy", busy, 1'b0);
    chk("r_run", run, 1'b0);
    chk("r_err", err, 1'b0);

    // FIFO wrap: 40 words through a 16-deep FIFO
    src_mode = 2; out_mode = 0;
    src_xfers = 0; saw_full = 0;
    send_cmd(2'd0, 39, 0);
    feed(40);
    repeat (24) tick();
    chk("f_full_in_ready", in_ready, 1'b0);
    src_mode = 3;
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    chk("f_saw_full", saw_full, 1'b1);
    chk_i("f_src_xfers", src_xfers, 40);
    chk("f_busy", busy, 1'b0);
    src_mode = 0;

    // dst_valid while IDLE
    acc_en = 0;
    dst_valid = 1'b1;
    chk("e_dst_ready_idle", dst_ready, 1'b0);
    tick();
    dst_valid = 1'b0;
    chk("e_err_set", err, 1'b1);
    tick();
    chk("e_err_sticky", err, 1'b1);
    src_xfers = 0;
    feed(1);
    send_cmd(2'd1, 0, 0);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk_i("e_src_xfers", src_xfers, 1);
    chk("e_err_after_cmd", err, 1'b1);

    // Reset in mid-RECV after 5 of 10 results
    acc_en = 1; dst_mode = 0; out_mode = 0;
    dst_xfers = 0;
    feed(2);
    send_cmd(2'd2, 1, 9);
    n = 0;
    while (dst_xfers < 5 && n < 100) begin tick(); n++; end
    chk_i("m_dst_xfers", dst_xfers, 5);
    chk("m_run_mid", run, 1'b1);
    acc_en = 0;
    dst_valid = 1'b0;
    recv_phase = 0;
    feed_q.delete();
    rst_n = 1'b0;
    tick();
    chk("m_run", run, 1'b0);
    chk("m_out_valid", out_valid, 1'b0);
    chk("m_err", err, 1'b0);
    chk("m_cmd_ready", cmd_ready, 1'b1);
    chk("m_busy", busy, 1'b0);
    chk("m_dst_ready", dst_ready, 1'b0);
    chk("m_in_ready", in_ready, 1'b1);
    clear_model();
    rst_n = 1'b1;
    tick();

    // Reserved op: accepted, stays IDLE, sets err
    send_cmd(2'd3, 0, 0);
    chk("x_busy", busy, 1'b0);
    chk("x_cmd_ready", cmd_ready, 1'b1);
    chk("x_err", err, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tiny_dnn_host_port.md
# tiny_dnn_host_port

Host-side stream master/slave for the tiny_dnn accelerator: it drives the accelerator's source stream (src_*) and mode strobes (wwrite/bwrite/run) from a host FIFO, and collects the destination stream (dst_*) back into a host-facing output stream. One command loads one weight block, one bias block, or one sample and then collects that sample's results. It sits between the host DMA/testbench and tiny_dnn_top.

## Interface
- DEPTH, 16: TX FIFO entries; power of two, at least 2.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cmd_valid / cmd_ready  in/out  1/1  command handshake; cmd_ready = (state==IDLE).
- cmd_op  in  2  0=weight, 1=bias, 2=run; 3 is reserved, accepted and ignored (stays IDLE, sets err).
- cmd_len  in  12  source words minus one (0..4095 means 1..4096 words).
- cmd_rlen  in  12  result words minus one (used by run only).
- in_valid / in_ready  in/out  1/1  host data push into the TX FIFO; in_ready = FIFO not full.
- in_data  in  real  source word.
- wwrite, bwrite, run  out  1  accelerator mode strobes.
- src_valid / src_ready  out/in  1/1  source handshake to the accelerator.
- src_data  out  real  FIFO head word.
- src_last  out  1  high with the final word of a command.
- dst_valid / dst_ready  in/out  1/1  result handshake from the accelerator.
- dst_data  in  real  result word.
- out_valid / out_ready  out/in  1/1  result stream to the host.
- out_data  out  real  result word.
- out_last  out  1  high with the final result word of a sample.
- busy  out  1  state!=IDLE.
- err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- States: IDLE, SETUP, SEND, RECV.
- IDLE: on cmd_valid, latch op/len/rlen, clear the word counters, and go to SETUP. Reserved op: set err and stay in IDLE.
- SETUP (exactly 1 cycle): the mode strobe for the op is high and src_valid=0. This gives the accelerator its (wwrite|bwrite)&~src_valid init cycle. Go to SEND.
- SEND: mode strobe held; src_valid = FIFO non-empty; src_data = FIFO head. A transfer is src_valid&src_ready; it pops the FIFO and increments tx_cnt.
  - src_last = src_valid & (tx_cnt==len).
  - On the last transfer: weight/bias go to IDLE (strobe drops the next cycle); run goes to RECV.
- RECV: run held; src_valid=0. dst_ready = output buffer (2 entries) not full. A transfer is dst_valid&dst_ready; it pushes to the output buffer and increments rx_cnt.
  - The entry with rx_cnt==rlen is tagged last.
  - After that transfer: go to IDLE; run drops the next cycle and dst_ready=0.
- Output buffer: 2-entry FIFO that drains independently of state. out_valid = not empty; the head carries its last tag onto out_last.
- Mode strobes are decoded from the state register and latched op only: at most one is high, with no combinational path from any input.
- TX FIFO: accepts pushes in any state. Read/write pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits. Push and pop in the same cycle leave the count unchanged.
- dst_valid outside RECV: the word is not accepted (dst_ready=0) and err is set.
- Counters are 12 bits. len=4095 sends 4096 words with no overflow, because the compare happens before the increment.

## Timing
- Reset (rst_n=0 at an edge) forces: state IDLE, FIFOs empty, counters 0.
  - Output values: cmd_ready=1, in_ready=1, all other outputs 0, src_data/out_data=0.0. This applies mid-operation too; an in-flight command is abandoned.
- Command accept to first possible src_valid: 2 cycles (accept edge -> SETUP, then -> SEND).
- Push-to-src latency: a word pushed at edge N is visible as src_data/src_valid from cycle N+1 (when in SEND).
- A full FIFO drops in_ready in the same cycle; a pop at edge N raises in_ready in cycle N+1.
- An accepted dst word appears on out_* the next cycle if the buffer was empty.
- Full output buffer: dst_ready=0; a simultaneous pop does not raise dst_ready until the next cycle.
- IDLE is re-entered one cycle after the final transfer; the next command can be accepted in that cycle.

## Test plan
- Weight load, len=3, 4 words pre-pushed, src_ready=1 -> wwrite high for 5 cycles (1 SETUP + 4 SEND); src_valid low in the SETUP cycle; src_last only on word 4; busy falls the next cycle.
- Bias, len=0, FIFO initially empty, word pushed 3 cycles later -> bwrite held with src_valid=0 until the push; one transfer with src_last=1.
- Run: len=783, rlen=9, random src_ready/out_ready stalls -> 784 in-order src words; 10 out words with out_last on the 10th; run drops after the 10th dst transfer.
- FIFO wrap: DEPTH=16, push 40 words continuously during SEND with src_ready toggling -> in_ready deasserts at count 16; data out matches input order; no loss.
- dst_valid=1 while IDLE -> dst_ready stays 0, err=1 and stays 1 across later commands until rst_n=0.
- rst_n=0 in mid-RECV after 5 of 10 results -> next cycle state IDLE, run=0, out_valid=0, err=0, cmd_ready=1.
